// File: rtl/microwave_ctrl_fsm_if.sv
// Button/door inputs and display/heater outputs of the microwave cook controller.
// The master side is the front panel, and the slave side is the controller.
interface microwave_ctrl_fsm_if;
    logic       add_min;
    logic       add_10s;
    logic       start;
    logic       stop;
    logic       door_open;
    logic [1:0] mode;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       heater_on;
    logic       beep;

    modport master (
        output add_min, add_10s, start, stop, door_open,
        input  mode, min_bcd, sec_bcd, heater_on, beep
    );

    modport slave (
        input  add_min, add_10s, start, stop, door_open,
        output mode, min_bcd, sec_bcd, heater_on, beep
    );
endinterface

// File: rtl/microwave_ctrl_fsm.sv
// Microwave cook-cycle controller. It holds a BCD mm:ss countdown timer and the cook FSM.
// Define MWAVE_DONE_BEEP_EN to drive beep for BEEP_TICKS second ticks on entry to DONE.
module microwave_ctrl_fsm #(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_MIN  = 99
`ifdef MWAVE_DONE_BEEP_EN
    ,
    parameter int BEEP_TICKS = 3
`endif
) (
    input logic                clk,
    input logic                rst_n,
    microwave_ctrl_fsm_if.slave bus
);

    localparam int         PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET,
        S_COOK,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [7:0]     r_min;
    logic [7:0]     r_sec;
    logic [PW-1:0]  r_presc;
    logic [1:0]     r_mode;
    logic           r_heater;
    logic           r_door_q;

    state_t         w_state_nxt;
    logic [15:0]    w_time_nxt;
    logic [15:0]    w_dec;
    logic [15:0]    w_base;
    logic [15:0]    w_added;
    logic [1:0]     w_mode_nxt;
    logic           w_heater_nxt;
    logic           w_run;
    logic           w_tick;
    logic           w_add;
    logic           w_btn;
    logic           w_start_ok;
    logic           w_door_rise;

    function automatic logic [7:0] inc_bcd(input logic [7:0] b);
        if (b[3:0] == 4'd9) return {b[7:4] + 4'd1, 4'd0};
        return {b[7:4], b[3:0] + 4'd1};
    endfunction

    // add_10s carries first, then +1 min; both saturate at MAX_MIN (MAX_MIN:59 on a saturated carry)
    function automatic logic [15:0] add_time(input logic [7:0] m, input logic [7:0] s,
                                             input logic do_min, input logic do_10s);
        logic [7:0] mm;
        logic [7:0] ss;
        mm = m;
        ss = s;
        if (do_10s) begin
            if (ss[7:4] == 4'd5) begin
                ss[7:4] = 4'd0;
                if (mm == MAX_MIN_BCD) ss = 8'h59;
                else                   mm = inc_bcd(mm);
            end else begin
                ss[7:4] = ss[7:4] + 4'd1;
            end
        end
        if (do_min && (mm != MAX_MIN_BCD)) mm = inc_bcd(mm);
        return {mm, ss};
    endfunction

    function automatic logic [15:0] dec_time(input logic [7:0] m, input logic [7:0] s);
        logic [7:0] mm;
        logic [7:0] ss;
        mm = m;
        ss = s;
        if (ss[3:0] != 4'd0) begin
            ss[3:0] = ss[3:0] - 4'd1;
        end else begin
            ss[3:0] = 4'd9;
            if (ss[7:4] != 4'd0) begin
                ss[7:4] = ss[7:4] - 4'd1;
            end else begin
                ss[7:4] = 4'd5;
                if (mm[3:0] != 4'd0) begin
                    mm[3:0] = mm[3:0] - 4'd1;
                end else begin
                    mm[3:0] = 4'd9;
                    mm[7:4] = mm[7:4] - 4'd1;
                end
            end
        end
        return {mm, ss};
    endfunction

`ifdef MWAVE_DONE_BEEP_EN
    localparam int BW = $clog2(BEEP_TICKS + 1);
    logic          r_beep;
    logic [BW-1:0] r_beep_cnt;
    logic          w_beep_nxt;
    logic [BW-1:0] w_beep_cnt_nxt;

    assign w_run = (r_state == S_COOK) || ((r_state == S_DONE) && r_beep);
`else
    assign w_run = (r_state == S_COOK);
`endif

    assign w_tick      = w_run && (r_presc == PW'(TICK_DIV - 1));
    assign w_add       = bus.add_min | bus.add_10s;
    assign w_btn       = w_add | bus.start | bus.stop;
    assign w_start_ok  = bus.start && !bus.door_open;
    assign w_door_rise = bus.door_open && !r_door_q;
    assign w_dec       = dec_time(r_min, r_sec);
    assign w_base      = ((r_state == S_COOK) && w_tick) ? w_dec : {r_min, r_sec};
    assign w_added     = add_time(w_base[15:8], w_base[7:0], bus.add_min, bus.add_10s);

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = {r_min, r_sec};
        case (r_state)
            S_IDLE: begin
                w_time_nxt = 16'h0000;
                if (!bus.stop && w_add) begin
                    w_state_nxt = S_SET;
                    w_time_nxt  = w_added;
                end
            end
            S_SET: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                    w_time_nxt  = 16'h0000;
                end else if (w_start_ok && ({r_min, r_sec} != 16'h0000)) begin
                    w_state_nxt = S_COOK;
                end else if (w_add) begin
                    w_time_nxt = w_added;
                end
            end
            S_COOK: begin
                // A tick landing together with stop/door still counts; reaching zero wins over PAUSE
                if (w_tick && (w_dec == 16'h0000)) begin
                    w_state_nxt = S_DONE;
                    w_time_nxt  = 16'h0000;
                end else if (bus.door_open || bus.stop) begin
                    w_state_nxt = S_PAUSE;
                    w_time_nxt  = w_base;
                end else if (w_add) begin
                    w_time_nxt = w_added;
                end else begin
                    w_time_nxt = w_base;
                end
            end
            S_PAUSE: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                    w_time_nxt  = 16'h0000;
                end else if (w_start_ok) begin
                    w_state_nxt = S_COOK;
                end else if (w_add) begin
                    w_time_nxt = w_added;
                end
            end
            S_DONE: begin
                w_time_nxt = 16'h0000;
                if (w_btn || w_door_rise) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_time_nxt  = 16'h0000;
            end
        endcase

        case (r_state)
            S_COOK:  w_mode_nxt = 2'b10;
            S_DONE:  w_mode_nxt = 2'b11;
            default: w_mode_nxt = bus.door_open ? 2'b01 : 2'b00;
        endcase

        w_heater_nxt = (w_state_nxt == S_COOK) && !bus.door_open;
    end

`ifdef MWAVE_DONE_BEEP_EN
    always_comb begin
        w_beep_nxt     = r_beep;
        w_beep_cnt_nxt = r_beep_cnt;
        if (w_state_nxt != S_DONE) begin
            w_beep_nxt     = 1'b0;
            w_beep_cnt_nxt = '0;
        end else if (r_state != S_DONE) begin
            w_beep_nxt     = 1'b1;
            w_beep_cnt_nxt = BW'(BEEP_TICKS);
        end else if (r_beep && w_tick) begin
            w_beep_cnt_nxt = r_beep_cnt - BW'(1);
            if (r_beep_cnt == BW'(1)) w_beep_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= '0;
        end else begin
            r_beep     <= w_beep_nxt;
            r_beep_cnt <= w_beep_cnt_nxt;
        end
    end

    assign bus.beep = r_beep;
`else
    assign bus.beep = 1'b0;
`endif

    // Prescaler is zero whenever it is not running, so every entry to COOK starts from 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_min    <= 8'h00;
            r_sec    <= 8'h00;
            r_presc  <= '0;
            r_mode   <= 2'b00;
            r_heater <= 1'b0;
            r_door_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_min    <= w_time_nxt[15:8];
            r_sec    <= w_time_nxt[7:0];
            r_presc  <= (w_run && !w_tick) ? r_presc + PW'(1) : '0;
            r_mode   <= w_mode_nxt;
            r_heater <= w_heater_nxt;
            r_door_q <= bus.door_open;
        end
    end

    assign bus.mode      = r_mode;
    assign bus.min_bcd   = r_min;
    assign bus.sec_bcd   = r_sec;
    assign bus.heater_on = r_heater;

endmodule

// File: tb/tb_microwave_ctrl_fsm.sv
// Directed bench for microwave_ctrl_fsm with TICK_DIV=4 (one second tick every 4 clocks).
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
module tb_microwave_ctrl_fsm;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    microwave_ctrl_fsm_if ifc ();

    microwave_ctrl_fsm #(
        .TICK_DIV(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic am, input logic a10, input logic st, input logic sp);
        ifc.add_min = am;
        ifc.add_10s = a10;
        ifc.start   = st;
        ifc.stop    = sp;
        @(posedge clk);
        #1;
        ifc.add_min = 1'b0;
        ifc.add_10s = 1'b0;
        ifc.start   = 1'b0;
        ifc.stop    = 1'b0;
    endtask

    task automatic press_n(input logic am, input logic a10, input int n);
        for (int i = 0; i < n; i++) press(am, a10, 1'b0, 1'b0);
    endtask

    task automatic check_time(input string tag, input logic [7:0] m, input logic [7:0] s);
        check({tag, ".min"}, ifc.min_bcd, m);
        check({tag, ".sec"}, ifc.sec_bcd, s);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        ifc.add_min   = 1'b0;
        ifc.add_10s   = 1'b0;
        ifc.start     = 1'b0;
        ifc.stop      = 1'b0;
        ifc.door_open = 1'b0;
        tick(2);
        check("rst.mode", {6'd0, ifc.mode}, 8'h00);
        check("rst.heater", {7'd0, ifc.heater_on}, 8'h00);
        check("rst.beep", {7'd0, ifc.beep}, 8'h00);
        check_time("rst", 8'h00, 8'h00);
        rst_n = 1'b1;
        tick(1);

        // 00:30 cook runs to DONE after 30 ticks
        press_n(1'b0, 1'b1, 3);
        check_time("set30", 8'h00, 8'h30);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1);
        check("cook.mode", {6'd0, ifc.mode}, 8'h02);
        check("cook.heater", {7'd0, ifc.heater_on}, 8'h01);
        tick(3);
        check_time("cook.t1", 8'h00, 8'h29);
        tick(115);
        check_time("cook.t29", 8'h00, 8'h01);
        check("cook.heater29", {7'd0, ifc.heater_on}, 8'h01);
        tick(1);
        check_time("done", 8'h00, 8'h00);
        check("done.heater", {7'd0, ifc.heater_on}, 8'h00);
        tick(1);
        check("done.mode", {6'd0, ifc.mode}, 8'h03);
`ifdef MWAVE_DONE_BEEP_EN
        check("beep.on", {7'd0, ifc.beep}, 8'h01);
        tick(10);
        check("beep.last", {7'd0, ifc.beep}, 8'h01);
        tick(1);
        check("beep.off", {7'd0, ifc.beep}, 8'h00);
`else
        check("beep.off", {7'd0, ifc.beep}, 8'h00);
`endif
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        check("done2idle.mode", {6'd0, ifc.mode}, 8'h00);

        // Asynchronous reset in the middle of a 01:30 cook
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press_n(1'b0, 1'b1, 3);
        check_time("set130", 8'h01, 8'h30);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tick(2);
        check("arst.pre_mode", {6'd0, ifc.mode}, 8'h02);
        rst_n = 1'b0;
        #1;
        check("arst.mode", {6'd0, ifc.mode}, 8'h00);
        check("arst.heater", {7'd0, ifc.heater_on}, 8'h00);
        check_time("arst", 8'h00, 8'h00);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Borrow, door pause, start blocked by door, resume
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tick(4);
        check_time("borrow", 8'h00, 8'h59);
        ifc.door_open = 1'b1;
        tick(1);
        check("door.heater", {7'd0, ifc.heater_on}, 8'h00);
        check_time("door.hold", 8'h00, 8'h59);
        tick(1);
        check("door.mode", {6'd0, ifc.mode}, 8'h01);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("door.start_ign", {7'd0, ifc.heater_on}, 8'h00);
        check("door.mode2", {6'd0, ifc.mode}, 8'h01);
        ifc.door_open = 1'b0;
        tick(1);
        check("closed.mode", {6'd0, ifc.mode}, 8'h00);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("resume.heater", {7'd0, ifc.heater_on}, 8'h01);
        tick(1);
        check("resume.mode", {6'd0, ifc.mode}, 8'h02);
        tick(3);
        check_time("resume.t1", 8'h00, 8'h58);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check("pause.heater", {7'd0, ifc.heater_on}, 8'h00);
        check_time("pause.hold", 8'h00, 8'h58);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check_time("pause.clear", 8'h00, 8'h00);

        // Saturation at 99:59
        press_n(1'b1, 1'b0, 100);
        check_time("sat.min", 8'h99, 8'h00);
        press_n(1'b0, 1'b1, 5);
        check_time("sat.50", 8'h99, 8'h50);
        press_n(1'b0, 1'b1, 1);
        check_time("sat.59", 8'h99, 8'h59);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check_time("sat.addmin", 8'h99, 8'h59);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check_time("sat.add10", 8'h99, 8'h59);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check_time("sat.both", 8'h99, 8'h59);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check_time("sat.clear", 8'h00, 8'h00);

        // Carry into minutes with both adds in one cycle: 00:50 -> 01:00 -> 02:00
        press_n(1'b0, 1'b1, 5);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check_time("both.carry", 8'h02, 8'h00);
        press(1'b0, 1'b0, 1'b0, 1'b1);

        // start+stop together, then start alone in IDLE
        press_n(1'b0, 1'b1, 2);
        check_time("set20", 8'h00, 8'h20);
        press(1'b0, 1'b0, 1'b1, 1'b1);
        check_time("startstop", 8'h00, 8'h00);
        check("startstop.heater", {7'd0, ifc.heater_on}, 8'h00);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("idle.start_heater", {7'd0, ifc.heater_on}, 8'h00);
        tick(1);
        check("idle.start_mode", {6'd0, ifc.mode}, 8'h00);

        // stop on the final tick goes to DONE, not PAUSE
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tick(36);
        check_time("last.pre", 8'h00, 8'h01);
        tick(3);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check_time("last.tick", 8'h00, 8'h00);
        check("last.heater", {7'd0, ifc.heater_on}, 8'h00);
        tick(1);
        check("last.mode", {6'd0, ifc.mode}, 8'h03);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check_time("done.addmin", 8'h00, 8'h00);
        tick(1);
        check("done.addmin_mode", {6'd0, ifc.mode}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
